// File: rtl/mul_multicycle_acc.sv
// Multicycle WIDTH x WIDTH -> 2*WIDTH multiplier built from four half-width partial products.
// Define MUL_ACC_EN to add the MADD/MSUB accumulate path (ACC state, hilo_i).
module mul_multicycle_acc #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_mul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               flush_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [2:0] {IDLE, PP, SUM, ACC, DONE} state_t;
  state_t state;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   pp_hh_d, pp_hl_d, pp_lh_d, pp_ll_d;
  logic [WIDTH-1:0]   pp_hh, pp_hl, pp_lh, pp_ll;
  logic               neg_r;
  logic [2*WIDTH-1:0] sum, prod;

  // Negating the most-negative value wraps back to itself, which read as unsigned is 2^(W-1).
  assign a_neg = signed_mul_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_mul_i & opdata2_i[WIDTH-1];
  assign a_abs = a_neg ? -opdata1_i : opdata1_i;
  assign b_abs = b_neg ? -opdata2_i : opdata2_i;

  assign pp_hh_d = {{HALF{1'b0}}, a_abs[WIDTH-1:HALF]} * {{HALF{1'b0}}, b_abs[WIDTH-1:HALF]};
  assign pp_hl_d = {{HALF{1'b0}}, a_abs[WIDTH-1:HALF]} * {{HALF{1'b0}}, b_abs[HALF-1:0]};
  assign pp_lh_d = {{HALF{1'b0}}, a_abs[HALF-1:0]}     * {{HALF{1'b0}}, b_abs[WIDTH-1:HALF]};
  assign pp_ll_d = {{HALF{1'b0}}, a_abs[HALF-1:0]}     * {{HALF{1'b0}}, b_abs[HALF-1:0]};

  assign sum = {pp_hh, {WIDTH{1'b0}}}
             + {{HALF{1'b0}}, pp_hl, {HALF{1'b0}}}
             + {{HALF{1'b0}}, pp_lh, {HALF{1'b0}}}
             + {{WIDTH{1'b0}}, pp_ll};
  assign prod = neg_r ? -sum : sum;

`ifdef MUL_ACC_EN
  logic [1:0]         op_r;
  logic [2*WIDTH-1:0] hilo_r, prod_r;
  logic               acc_op;
  assign acc_op = (op_r == 2'b01) || (op_r == 2'b10);
`else
  logic unused_acc;
  assign unused_acc = ^{op_i, hilo_i};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_o <= '0;
      ready_o  <= 1'b0;
      stall_o  <= 1'b0;
      neg_r    <= 1'b0;
      pp_hh    <= '0;
      pp_hl    <= '0;
      pp_lh    <= '0;
      pp_ll    <= '0;
`ifdef MUL_ACC_EN
      op_r     <= 2'b00;
      hilo_r   <= '0;
      prod_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !flush_i) begin
            pp_hh   <= pp_hh_d;
            pp_hl   <= pp_hl_d;
            pp_lh   <= pp_lh_d;
            pp_ll   <= pp_ll_d;
            neg_r   <= a_neg ^ b_neg;
`ifdef MUL_ACC_EN
            op_r    <= op_i;
            hilo_r  <= hilo_i;
`endif
            stall_o <= 1'b1;
            state   <= PP;
          end
        end
        PP: begin
          if (flush_i) begin
            stall_o <= 1'b0;
            ready_o <= 1'b0;
            state   <= IDLE;
          end
`ifdef MUL_ACC_EN
          else if (acc_op) begin
            prod_r <= prod;
            state  <= ACC;
          end
`endif
          else begin
            result_o <= prod;
            ready_o  <= 1'b1;
            stall_o  <= 1'b0;
            state    <= DONE;
          end
        end
`ifdef MUL_ACC_EN
        ACC: begin
          if (flush_i) begin
            stall_o <= 1'b0;
            ready_o <= 1'b0;
            state   <= IDLE;
          end else begin
            result_o <= (op_r == 2'b10) ? hilo_r - prod_r : hilo_r + prod_r;
            ready_o  <= 1'b1;
            stall_o  <= 1'b0;
            state    <= DONE;
          end
        end
`endif
        // start_i is deliberately not looked at here; re-accept happens in IDLE.
        DONE: begin
          ready_o <= 1'b0;
          stall_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b0;
          stall_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_multicycle_acc.sv
// Scoreboard bench for mul_multicycle_acc: 32-bit instance plus a 16-bit instance.
// Expected results are queued at issue time and popped when ready_o pulses.
module tb_mul_multicycle_acc;
  localparam int W = 32;
`ifdef MUL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start, sg, flush;
  logic [1:0]    op;
  logic [W-1:0]  opa, opb;
  logic [63:0]   hilo, result;
  logic          ready, stall;

  logic          start16, sg16, flush16;
  logic [1:0]    op16;
  logic [15:0]   a16, b16;
  logic [31:0]   hilo16, result16;
  logic          ready16, stall16;

  mul_multicycle_acc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_mul_i(sg), .op_i(op),
    .opdata1_i(opa), .opdata2_i(opb), .hilo_i(hilo), .flush_i(flush),
    .result_o(result), .ready_o(ready), .stall_o(stall));

  mul_multicycle_acc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .signed_mul_i(sg16), .op_i(op16),
    .opdata1_i(a16), .opdata2_i(b16), .hilo_i(hilo16), .flush_i(flush16),
    .result_o(result16), .ready_o(ready16), .stall_o(stall16));

  always #5 clk = ~clk;

  int          tests_run = 0, tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'h0;

  function automatic logic [63:0] model(input bit s, input logic [1:0] o,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] h);
    logic [63:0] p;
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (s) p = sa * sb;
    else   p = {32'h0, a} * {32'h0, b};
    if (ACC_EN && o == 2'b01) return h + p;
    if (ACC_EN && o == 2'b10) return h - p;
    return p;
  endfunction

  function automatic int lat_of(input logic [1:0] o);
    return (ACC_EN && (o == 2'b01 || o == 2'b10)) ? 3 : 2;
  endfunction

  // Drives one request for a single accept edge, then scrambles the inputs.
  task automatic issue(input bit s, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h);
    @(negedge clk);
    start = 1'b1; sg = s; op = o; opa = a; opb = b; hilo = h;
    exp_q.push_back(model(s, o, a, b, h));
    @(negedge clk);
    start = 1'b0; sg = 1'($urandom); op = 2'($urandom);
    opa = $urandom; opb = $urandom; hilo = {$urandom, $urandom};
  endtask

  // Counts edges from the accept edge (edge 1) until ready_o is seen.
  task automatic wait_ready(output int edges);
    edges = 1;
    while (!ready && edges < 12) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (result !== 64'h0 || ready !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset32: result=%h ready=%b stall=%b, want 0/0/0", result, ready, stall);
    end
    tests_run++;
    if (result16 !== 32'h0 || ready16 !== 1'b0 || stall16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset16: result=%h ready=%b stall=%b, want 0/0/0", result16, ready16, stall16);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_mult;
    int edges;
    logic [63:0] e;
    issue(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    tests_run++;
    if (stall !== 1'b1 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL umul_stall: stall=%b ready=%b, want 1/0", stall, ready);
    end
    wait_ready(edges);
    tests_run++;
    if (edges !== 2) begin
      tests_failed++;
      $display("FAIL umul_latency: edges=%0d, want 2", edges);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (result !== 64'hFFFF_FFFE_0000_0001 || result !== e || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL umul_result: result=%h stall=%b, want %h/0", result, stall, 64'hFFFF_FFFE_0000_0001);
    end
    last_exp = e;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b0 || result !== last_exp) begin
      tests_failed++;
      $display("FAIL umul_pulse: ready=%b result=%h, want 0/%h", ready, result, last_exp);
    end
  endtask

  task automatic test_signed_mult;
    logic [31:0] va[5] = '{32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h7};
    logic [31:0] vb[5] = '{32'h7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [63:0] ve[5] = '{64'hFFFF_FFFF_FFFF_FFDD, 64'h0000_0000_8000_0000,
                           64'h4000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFDD};
    int edges;
    logic [63:0] e;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 2'b00, va[i], vb[i], 64'h0);
      wait_ready(edges);
      e = exp_q.pop_front();
      tests_run++;
      if (edges !== 2 || result !== ve[i] || e !== ve[i]) begin
        tests_failed++;
        $display("FAIL smul_%0d: result=%h edges=%0d, want %h at 2", i, result, edges, ve[i]);
      end
      last_exp = ve[i];
      @(negedge clk);
    end
  endtask

  task automatic test_acc;
    logic [1:0]  vo[3] = '{2'b01, 2'b10, 2'b11};
    bit          vs[3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] va[3] = '{32'h3, 32'h2, 32'hFFFF_FFFF};
    logic [31:0] vb[3] = '{32'h4, 32'h3, 32'hFFFF_FFFF};
    logic [63:0] vh[3] = '{64'h0000_0001_0000_0000, 64'h0, 64'h1234_0000_0000_0000};
    logic [63:0] ve[3];
    int edges;
    logic [63:0] e;
    ve[0] = ACC_EN ? 64'h0000_0001_0000_000C : 64'hC;
    ve[1] = ACC_EN ? 64'hFFFF_FFFF_FFFF_FFFA : 64'h6;
    ve[2] = 64'h1;
    for (int i = 0; i < 3; i++) begin
      issue(vs[i], vo[i], va[i], vb[i], vh[i]);
      wait_ready(edges);
      e = exp_q.pop_front();
      tests_run++;
      if (edges !== lat_of(vo[i]) || result !== ve[i] || e !== ve[i] || stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL acc_%0d: result=%h edges=%0d stall=%b, want %h at %0d", i, result, edges,
                 stall, ve[i], lat_of(vo[i]));
      end
      last_exp = ve[i];
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int edges;
    logic [63:0] e;
    logic [1:0] o;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom);
      issue(1'($urandom), o, $urandom, $urandom, {$urandom, $urandom});
      wait_ready(edges);
      e = exp_q.pop_front();
      tests_run++;
      if (edges !== lat_of(o) || result !== e) begin
        tests_failed++;
        $display("FAIL rand_%0d: result=%h edges=%0d, want %h at %0d", i, result, edges, e, lat_of(o));
      end
      last_exp = e;
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    int pulses;
    // Flush while in PP.
    issue(1'b0, 2'b00, 32'h1234, 32'h5678, 64'h0);
    void'(exp_q.pop_front());
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (stall !== 1'b0 || ready !== 1'b0 || result !== last_exp) begin
      tests_failed++;
      $display("FAIL flush_pp: stall=%b ready=%b result=%h, want 0/0/%h", stall, ready, result, last_exp);
    end
    pulses = 0;
    repeat (5) begin @(negedge clk); if (ready) pulses++; end
    tests_run++;
    if (pulses !== 0 || result !== last_exp) begin
      tests_failed++;
      $display("FAIL flush_pp_quiet: pulses=%0d result=%h, want 0/%h", pulses, result, last_exp);
    end
    // Flush while in ACC (or DONE in a multiply-only build).
    issue(1'b0, 2'b01, 32'h9, 32'h9, 64'h77);
    void'(exp_q.pop_front());
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    pulses = 0;
    repeat (4) begin @(negedge clk); if (ready) pulses++; end
    if (!ACC_EN) last_exp = 64'h51;
    tests_run++;
    if (pulses !== 0 || stall !== 1'b0 || result !== last_exp) begin
      tests_failed++;
      $display("FAIL flush_late: pulses=%0d stall=%b result=%h, want 0/0/%h", pulses, stall, result, last_exp);
    end
    // Flush and start together in IDLE: request dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; sg = 1'b0; op = 2'b00; opa = 32'h3; opb = 32'h3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    pulses = 0;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_stall: stall=%b, want 0", stall);
    end
    repeat (4) begin @(negedge clk); if (ready) pulses++; end
    tests_run++;
    if (pulses !== 0 || result !== last_exp) begin
      tests_failed++;
      $display("FAIL flush_idle_drop: pulses=%0d result=%h, want 0/%h", pulses, result, last_exp);
    end
  endtask

  task automatic test_back_to_back;
    int idx[$];
    logic [63:0] e, m;
    m = model(1'b0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0);
    @(negedge clk);
    start = 1'b1; sg = 1'b0; op = 2'b00; opa = 32'h1234_5678; opb = 32'h9ABC_DEF0; hilo = 64'h0;
    repeat (3) exp_q.push_back(m);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (ready) begin
        idx.push_back(i);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~m;
        tests_run++;
        if (result !== e) begin
          tests_failed++;
          $display("FAIL b2b_result_%0d: result=%h, want %h", i, result, e);
        end
      end
    end
    start = 1'b0;
    last_exp = m;
    tests_run++;
    if (idx.size() !== 3 || idx[0] !== 1 || idx[1] !== 4 || idx[2] !== 7) begin
      tests_failed++;
      $display("FAIL b2b_spacing: pulses=%0d, want 3 at cycles 1,4,7", idx.size());
    end
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 2'b00, 32'hFFFF_FFF0, 32'h10, 64'h0);
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (result !== 64'h0 || ready !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: result=%h ready=%b stall=%b, want 0/0/0", result, ready, stall);
    end
    last_exp = 64'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_width16;
    logic [15:0] va[2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] vb[2] = '{16'hFFFF, 16'h8000};
    bit          vs[2] = '{1'b0, 1'b1};
    logic [31:0] ve[2] = '{32'hFFFE_0001, 32'h0000_8000};
    int edges;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start16 = 1'b1; sg16 = vs[i]; a16 = va[i]; b16 = vb[i];
      @(negedge clk);
      start16 = 1'b0; a16 = 16'h1; b16 = 16'h1;
      edges = 1;
      while (!ready16 && edges < 12) begin @(negedge clk); edges++; end
      tests_run++;
      if (edges !== 2 || result16 !== ve[i]) begin
        tests_failed++;
        $display("FAIL w16_%0d: result=%h edges=%0d, want %h at 2", i, result16, edges, ve[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sg = 1'b0; flush = 1'b0; op = 2'b00;
    opa = '0; opb = '0; hilo = '0;
    start16 = 1'b0; sg16 = 1'b0; flush16 = 1'b0; op16 = 2'b00;
    a16 = '0; b16 = '0; hilo16 = '0;
    test_reset();
    test_unsigned_mult();
    test_signed_mult();
    test_acc();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_width16();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
